// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: Tuse/forward
// encodings, the scoreboard entry layout and the saturating Tnew decrement.
package hazard_pkg;

    localparam logic [3:0] TUSE_NONE = 4'd4;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] tnew;
    } sb_entry_t;

    function automatic logic [3:0] sat_dec(input logic [3:0] x);
        return (x != 4'd0) ? x - 4'd1 : 4'd0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Countdown window for the multi-cycle mult/div unit; busy while a start is
// presented or the loaded count has not yet drained to zero.
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CW          = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          is_div_i,
    output logic          busy_o,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q, count_d;

    // A start always reloads, even mid-window.
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = is_div_i ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o  = !reset && (start_i || (count_q != '0));
    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline: tracks in-flight
// destinations per E/M/W stage and resolves them against decode-stage Tuse.
module hazard_ctrl #(
    parameter int         MULT_CYCLES = 5,
    parameter int         DIV_CYCLES  = 10,
    parameter logic [3:0] TUSE_NONE   = 4'd4,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs_addr,
    input  logic [4:0]       d_rt_addr,
    input  logic [3:0]       d_rs_use,
    input  logic [3:0]       d_rt_use,
    input  logic [4:0]       d_dst_addr,
    input  logic [3:0]       d_dst_save,
    input  logic             d_md_use,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    output logic             stall,
    output logic             if_enable,
    output logic             id_enable,
    output logic             ex_flush,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);
    import hazard_pkg::*;

    localparam int MD_CW = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);

    sb_entry_t        e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_busy_w;
    logic [MD_CW-1:0] md_count_w;
    logic             stall_raw;
    logic [1:0]       rs_sel_raw, rt_sel_raw;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CW         (MD_CW)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (e_md_start),
        .is_div_i(e_md_is_div),
        .busy_o  (md_busy_w),
        .count_o (md_count_w)
    );

    function automatic logic hit(input logic [4:0] op, input logic [3:0] use_v,
                                 input sb_entry_t x);
        return (x.addr != 5'd0) && (x.addr == op) && (use_v != TUSE_NONE);
    endfunction

    function automatic logic must_wait(input logic [4:0] op, input logic [3:0] use_v,
                                       input sb_entry_t x);
        return hit(op, use_v, x) && (use_v < x.tnew);
    endfunction

    // A matched E entry that is not ready yet hides older stages: its value
    // supersedes theirs, and the stall logic covers the wait.
    function automatic logic [1:0] src_sel(input logic [4:0] op, input logic [3:0] use_v,
                                           input sb_entry_t e, input sb_entry_t m,
                                           input sb_entry_t w);
        if (hit(op, use_v, e)) begin
            return (e.tnew == 4'd0) ? FWD_E : FWD_GRF;
        end
        if (hit(op, use_v, m) && (m.tnew == 4'd0)) begin
            return FWD_M;
        end
        if (hit(op, use_v, w)) begin
            return FWD_W;
        end
        return FWD_GRF;
    endfunction

    always_comb begin
        stall_raw  = must_wait(d_rs_addr, d_rs_use, e_q) || must_wait(d_rs_addr, d_rs_use, m_q) ||
                     must_wait(d_rt_addr, d_rt_use, e_q) || must_wait(d_rt_addr, d_rt_use, m_q) ||
                     (d_md_use && md_busy_w);
        rs_sel_raw = src_sel(d_rs_addr, d_rs_use, e_q, m_q, w_q);
        rt_sel_raw = src_sel(d_rt_addr, d_rt_use, e_q, m_q, w_q);
    end

    assign stall       = !reset && stall_raw;
    assign if_enable   = !stall;
    assign id_enable   = !stall;
    assign ex_flush    = stall;
    assign fwd_rs_sel  = reset ? FWD_GRF : rs_sel_raw;
    assign fwd_rt_sel  = reset ? FWD_GRF : rt_sel_raw;
    assign md_busy     = md_busy_w;
    assign stall_count = cnt_q;

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.addr = d_dst_addr;
            e_d.tnew = d_dst_save;
        end
        m_d.addr = e_q.addr;
        m_d.tnew = sat_dec(e_q.tnew);
        w_d.addr = m_q.addr;
        w_d.tnew = sat_dec(m_q.tnew);
        cnt_d    = stall ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic,
// checked against an issue-history model through an expected-output queue.
module tb_hazard_ctrl;

    localparam int W     = 25;
    localparam int NC    = 4096;
    localparam int N_RND = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs_addr, d_rt_addr, d_dst_addr;
    logic [3:0]  d_rs_use, d_rt_use, d_dst_save;
    logic        d_md_use, e_md_start, e_md_is_div;
    logic        stall, if_enable, id_enable, ex_flush, md_busy;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs_addr  (d_rs_addr),
        .d_rt_addr  (d_rt_addr),
        .d_rs_use   (d_rs_use),
        .d_rt_use   (d_rt_use),
        .d_dst_addr (d_dst_addr),
        .d_dst_save (d_dst_save),
        .d_md_use   (d_md_use),
        .e_md_start (e_md_start),
        .e_md_is_div(e_md_is_div),
        .stall      (stall),
        .if_enable  (if_enable),
        .id_enable  (id_enable),
        .ex_flush   (ex_flush),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy),
        .stall_count(stall_count)
    );

    // Model state: what entered E at the end of each cycle, when the MDU
    // window ends, and the number of stalled cycles since reset.
    int          iss_addr [NC];
    int          iss_save [NC];
    int          cyc;
    int          md_end;
    int          cnt;
    logic [W-1:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic bit hit(int op, int use_v, int addr);
        return (addr != 0) && (addr == op) && (use_v != 4);
    endfunction

    function automatic int src(int op, int use_v, int a0, int t0, int a1, int t1, int a2);
        if (hit(op, use_v, a0)) return (t0 == 0) ? 1 : 0;
        if (hit(op, use_v, a1) && t1 == 0) return 2;
        if (hit(op, use_v, a2)) return 3;
        return 0;
    endfunction

    task automatic drive_cycle(input bit r, input int rs, input int rsu, input int rt,
                               input int rtu, input int dst, input int save,
                               input bit mduse, input bit start, input bit isdiv);
        int  ad [3];
        int  tn [3];
        bit  busy, stl, need;
        int  rs_s, rt_s;
        @(posedge clk);
        #1;
        reset       = r;
        d_rs_addr   = 5'(rs);
        d_rs_use    = 4'(rsu);
        d_rt_addr   = 5'(rt);
        d_rt_use    = 4'(rtu);
        d_dst_addr  = 5'(dst);
        d_dst_save  = 4'(save);
        d_md_use    = mduse;
        e_md_start  = start;
        e_md_is_div = isdiv;
        cyc++;
        for (int a = 0; a < 3; a++) begin
            ad[a] = iss_addr[cyc-1-a];
            tn[a] = (iss_save[cyc-1-a] > a) ? iss_save[cyc-1-a] - a : 0;
        end
        need = 1'b0;
        for (int a = 0; a < 2; a++) begin
            if (hit(rs, rsu, ad[a]) && rsu < tn[a]) need = 1'b1;
            if (hit(rt, rtu, ad[a]) && rtu < tn[a]) need = 1'b1;
        end
        busy = !r && (start || cyc <= md_end);
        stl  = !r && (need || (mduse && busy));
        rs_s = r ? 0 : src(rs, rsu, ad[0], tn[0], ad[1], tn[1], ad[2]);
        rt_s = r ? 0 : src(rt, rtu, ad[0], tn[0], ad[1], tn[1], ad[2]);
        exp_q.push_back({stl, !stl, !stl, stl, 2'(rs_s), 2'(rt_s), busy, 16'(cnt)});
        if (r) begin
            for (int a = 0; a < 3; a++) begin
                iss_addr[cyc-a] = 0;
                iss_save[cyc-a] = 0;
            end
            md_end = -1;
            cnt    = 0;
        end else begin
            iss_addr[cyc] = stl ? 0 : dst;
            iss_save[cyc] = stl ? 0 : save;
            if (start) md_end = cyc + (isdiv ? 10 : 5);
            cnt = (cnt + int'(stl)) % 65536;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 4, 0, 4, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e, g;
            e = exp_q.pop_front();
            g = {stall, if_enable, id_enable, ex_flush, fwd_rs_sel, fwd_rt_sel, md_busy, stall_count};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got stall=%b ife=%b ide=%b flush=%b rs=%0d rt=%0d busy=%b cnt=%0d, exp stall=%b ife=%b ide=%b flush=%b rs=%0d rt=%0d busy=%b cnt=%0d",
                         $time, g[24], g[23], g[22], g[21], g[20:19], g[18:17], g[16], g[15:0],
                         e[24], e[23], e[22], e[21], e[20:19], e[18:17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            iss_addr[i] = 0;
            iss_save[i] = 0;
        end
        cyc    = 2;
        md_end = -1;
        cnt    = 0;
        reset = 1'b1;
        d_rs_addr = '0; d_rt_addr = '0; d_dst_addr = '0;
        d_rs_use = 4'd4; d_rt_use = 4'd4; d_dst_save = '0;
        d_md_use = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0;
        repeat (2) @(posedge clk);
        drive_cycle(1, 0, 4, 0, 4, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on r8: two stall cycles, then forward from W
        drive_cycle(0, 0, 4, 0, 4, 8, 2, 0, 0, 0);
        repeat (3) drive_cycle(0, 8, 0, 0, 4, 0, 0, 0, 0, 0);
        idle(3);
        // same producer, consumer with Tuse 1
        drive_cycle(0, 0, 4, 0, 4, 8, 2, 0, 0, 0);
        repeat (3) drive_cycle(0, 8, 1, 0, 4, 0, 0, 0, 0, 0);
        idle(3);
        // ALU back-to-back on rt
        drive_cycle(0, 0, 4, 0, 4, 9, 0, 0, 0, 0);
        drive_cycle(0, 0, 4, 9, 0, 0, 0, 0, 0, 0);
        idle(3);
        // $0 never matches; TUSE_NONE never stalls
        drive_cycle(0, 0, 4, 0, 4, 0, 2, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 4, 0, 4, 5, 2, 0, 0, 0);
        drive_cycle(0, 5, 4, 5, 4, 0, 0, 0, 0, 0);
        idle(3);
        // priority E over M, and a not-ready E blocking M
        drive_cycle(0, 0, 4, 0, 4, 3, 0, 0, 0, 0);
        drive_cycle(0, 0, 4, 0, 4, 3, 0, 0, 0, 0);
        drive_cycle(0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 4, 0, 4, 3, 0, 0, 0, 0);
        drive_cycle(0, 0, 4, 0, 4, 3, 1, 0, 0, 0);
        drive_cycle(0, 3, 1, 0, 4, 0, 0, 0, 0, 0);
        idle(3);
        drive_cycle(0, 0, 4, 0, 4, 3, 0, 0, 0, 0);
        drive_cycle(0, 0, 4, 0, 4, 3, 1, 0, 0, 0);
        drive_cycle(0, 3, 0, 0, 4, 0, 0, 0, 0, 0);
        idle(3);
        // div window with an mflo waiting, then a mult window
        drive_cycle(0, 0, 4, 0, 4, 0, 0, 0, 1, 1);
        repeat (12) drive_cycle(0, 0, 4, 0, 4, 0, 0, 1, 0, 0);
        idle(2);
        drive_cycle(0, 0, 4, 0, 4, 0, 0, 0, 1, 0);
        idle(7);
        // reset while the div counter sits at 7 with a stalled mflo
        drive_cycle(0, 0, 4, 0, 4, 0, 0, 0, 1, 1);
        repeat (3) drive_cycle(0, 0, 4, 0, 4, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 4, 0, 4, 0, 0, 1, 0, 0);
        drive_cycle(0, 0, 4, 0, 4, 0, 0, 1, 0, 0);
        idle(2);

        for (int i = 0; i < N_RND; i++) begin
            drive_cycle($urandom_range(0, 149) == 0,
                        $urandom_range(0, 7), $urandom_range(0, 4),
                        $urandom_range(0, 7), $urandom_range(0, 4),
                        $urandom_range(0, 7), $urandom_range(0, 3),
                        $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                        $urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
